// File: rtl/hardreg.sv
// WIDTH-bit parallel register built from per-bit D flip-flops,
// each with its own asynchronous active-high clear.
module hardreg_cell #(
  parameter logic RV = 1'b0
) (
  input  logic clk,
  input  logic clrb,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clrb) begin
    if (clrb) q <= RV;
    else      q <= d;
  end

endmodule

module hardreg #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    hardreg_cell #(
      .RV(RESET_VALUE[i])
    ) u_cell (
      .clk (clk),
      .clrb(clrb),
      .d   (d[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_hardreg.sv
// Scoreboard bench for hardreg: default 4-bit instance and an
// 8-bit instance with a non-zero clear value.
module tb_hardreg;

  logic       clk;
  logic       clrb;
  logic [3:0] d;
  logic [3:0] q;
  logic       clr8;
  logic [7:0] d8;
  logic [7:0] q8;

  int pass_cnt = 0;
  int total    = 0;

  logic [3:0] sb4[$];
  logic [7:0] sb8[$];

  hardreg dut (
    .clk (clk),
    .clrb(clrb),
    .d   (d),
    .q   (q)
  );

  hardreg #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5)
  ) dut8 (
    .clk (clk),
    .clrb(clr8),
    .d   (d8),
    .q   (q8)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic test_reset();
    logic [3:0] exp;
    exp = 4'b0000;
    #1;
    total++;
    if (q !== exp)
      $display("FAIL reset_immediate q=%b exp=%b", q, exp);
    else pass_cnt++;
    total++;
    if (q8 !== 8'hA5)
      $display("FAIL reset8_immediate q=%h exp=a5", q8);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (q !== exp)
        $display("FAIL reset_hold_edge%0d q=%b exp=%b", i, q, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_seq_load();
    logic [3:0] seq[5];
    logic [3:0] exp;
    seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101};
    @(negedge clk);
    clrb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d = seq[i];
      sb4.push_back(seq[i]);
      #1;
      total++;
      if (i > 0 && q !== seq[i-1])
        $display("FAIL seq_pre%0d q=%b exp=%b", i, q, seq[i-1]);
      else pass_cnt++;
      @(posedge clk);
      #1;
      exp = sb4.pop_front();
      total++;
      if (q !== exp)
        $display("FAIL seq_load%0d q=%b exp=%b", i, q, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    logic [3:0] exp;
    @(negedge clk);
    d = 4'b0010;
    sb4.push_back(4'b0010);
    @(posedge clk);
    #1;
    exp = sb4.pop_front();
    total++;
    if (q !== exp)
      $display("FAIL hold_cap q=%b exp=%b", q, exp);
    else pass_cnt++;
    #10 d = 4'b1111;
    #10;
    total++;
    if (q !== exp)
      $display("FAIL hold_d1111 q=%b exp=%b", q, exp);
    else pass_cnt++;
    d = 4'b0010;
    #10;
    total++;
    if (q !== exp)
      $display("FAIL hold_back q=%b exp=%b", q, exp);
    else pass_cnt++;
  endtask

  task automatic test_async_clear();
    logic [3:0] exp;
    @(negedge clk);
    d = 4'b0101;
    sb4.push_back(4'b0101);
    @(posedge clk);
    #1;
    exp = sb4.pop_front();
    total++;
    if (q !== exp)
      $display("FAIL aclr_cap q=%b exp=%b", q, exp);
    else pass_cnt++;
    #19 clrb = 1'b1;
    #1;
    total++;
    if (q !== 4'b0000)
      $display("FAIL aclr_immediate q=%b exp=0000", q);
    else pass_cnt++;
    #10 clrb = 1'b0;
    d = 4'b0100;
    #5;
    total++;
    if (q !== 4'b0000)
      $display("FAIL aclr_release q=%b exp=0000", q);
    else pass_cnt++;
    sb4.push_back(4'b0100);
    @(posedge clk);
    #1;
    exp = sb4.pop_front();
    total++;
    if (q !== exp)
      $display("FAIL aclr_next q=%b exp=%b", q, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq[5];
    logic [3:0] exp;
    seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        d = seq[i];
        sb4.push_back(seq[i]);
        @(posedge clk);
        #1;
        exp = sb4.pop_front();
        total++;
        if (q !== exp)
          $display("FAIL b2b_r%0d_i%0d q=%b exp=%b", r, i, q, exp);
        else pass_cnt++;
      end
    end
    #200;
    total++;
    if (q !== 4'b0101)
      $display("FAIL b2b_tail q=%b exp=0101", q);
    else pass_cnt++;
  endtask

  task automatic test_xprop();
    logic [3:0] exp;
    @(negedge clk);
    d = 4'b1x01;
    sb4.push_back(4'b1x01);
    @(posedge clk);
    #1;
    exp = sb4.pop_front();
    total++;
    if (q !== exp)
      $display("FAIL xprop q=%b exp=%b", q, exp);
    else pass_cnt++;
    @(negedge clk);
    d = 4'b1010;
    sb4.push_back(4'b1010);
    @(posedge clk);
    #1;
    exp = sb4.pop_front();
    total++;
    if (q !== exp)
      $display("FAIL xclear q=%b exp=%b", q, exp);
    else pass_cnt++;
  endtask

  task automatic test_param();
    logic [7:0] pats[4];
    logic [7:0] exp;
    pats = '{8'h3C, 8'h01, 8'h80, 8'h5A};
    @(negedge clk);
    clr8 = 1'b1;
    #1;
    total++;
    if (q8 !== 8'hA5)
      $display("FAIL p8_clear q=%h exp=a5", q8);
    else pass_cnt++;
    @(negedge clk);
    clr8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d8 = pats[i];
      sb8.push_back(pats[i]);
      @(posedge clk);
      #1;
      exp = sb8.pop_front();
      total++;
      if (q8 !== exp)
        $display("FAIL p8_load%0d q=%h exp=%h", i, q8, exp);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    clrb = 1'b1;
    clr8 = 1'b1;
    d    = 4'b0101;
    d8   = 8'h3C;
    test_reset();
    test_seq_load();
    test_hold();
    test_async_clear();
    test_back_to_back();
    test_xprop();
    test_param();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hardreg.md
HARDREG -- requirements
Module: hardreg

Interface
REQ-001 Parameter WIDTH, default 4: data width of d and q; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into q on clear; width WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge except clear.
REQ-004 clrb  input  1  asynchronous, active-high clear/reset.
REQ-005 d  input  WIDTH  parallel data to be captured.
REQ-006 q  output  WIDTH  registered data; driven directly from storage, no combinational path from d.

Function
REQ-007 The block SHALL be a WIDTH-bit parallel-in/parallel-out edge-triggered register.
REQ-008 On each rising clk edge with clrb low, q SHALL take the value of d sampled at that edge.
REQ-009 Latency d->q SHALL be exactly one clk rising edge; q SHALL hold between edges regardless of d activity.
REQ-010 Each bit SHALL be an independent per-bit D flip-flop cell with its own asynchronous clear, instantiated WIDTH times.
REQ-011 Bits SHALL map index-for-index: q[i] captures d[i]; no reordering, inversion or arithmetic.
REQ-012 d changing away from a clk edge SHALL NOT affect q.
REQ-013 X/Z on d at a capturing edge SHALL propagate to the corresponding q bit only; other bits are unaffected.
REQ-014 No enable: every rising edge with clrb low captures d, including unchanged data.

Reset
REQ-015 While clrb is high, q SHALL equal RESET_VALUE (default 4'b0000) immediately, without waiting for a clk edge.
REQ-016 While clrb is high, rising clk edges SHALL be ignored; q stays RESET_VALUE.
REQ-017 Clear asserted mid-cycle SHALL override any previously captured value within the same simulation time step.
REQ-018 On clrb deassertion (high->low), q SHALL remain RESET_VALUE until the first subsequent rising clk edge, which captures d.
REQ-019 clrb and a rising clk edge at the same instant with clrb going high: clear wins, q = RESET_VALUE.
REQ-020 clrb deasserting at the same instant as a rising clk edge: that edge is ignored; capture starts on the next edge.
REQ-021 q's power-up value before any clear or clk edge is undefined (X) and SHALL NOT be relied on.

Verification
REQ-022 Clear: clrb=1 at t=0, d=4'b0101, clk toggling period 100 -> q=4'b0000 immediately and through all edges while clrb=1.
REQ-023 Sequential load: clrb=0; apply d=0000,0001,0010,0100,0101 each for one 100-unit period -> q shows each value one rising edge after it is applied; final q=0101 (decimal 5).
REQ-024 Hold: d=0010 captured, then d changes to 1111 and back to 0010 between edges -> q stays 0010 until next edge.
REQ-025 Async clear mid-cycle: q=0101, raise clrb 20 units after a rising edge -> q=0000 at that instant; release clrb, next edge with d=0100 -> q=0100.
REQ-026 Repeat: run the 5-value sequence of REQ-023 twice back-to-back -> q repeats 0000,0001,0010,0100,0101 identically; after 200 further units with d=0101, q=0101.
REQ-027 Parameter check: WIDTH=8, RESET_VALUE=8'hA5 -> clear gives q=8'hA5; d=8'h3C captured on next edge after release gives q=8'h3C.
